// File: rtl/frame_dump_pkg.sv
// Shared types and defaults for the frame buffer UART dump controller.
package frame_dump_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR0,
        ST_HDR1,
        ST_ADDR,
        ST_LATCH,
        ST_BYTE,
        ST_WBUSY
    } state_t;

    localparam int unsigned WIDTH_DEF     = 40;
    localparam int unsigned HEIGHT_DEF    = 30;
    localparam int unsigned HOLDOFF_W_DEF = 13;
    localparam int unsigned TIMEOUT_CYC   = 4;
    localparam logic [7:0]  SYNC0_DEF     = 8'hA5;
    localparam logic [7:0]  SYNC1_DEF     = 8'h5A;

    // Index width for a 0..n-1 counter, never narrower than one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/frame_dump_ctrl_holdoff.sv
// Inter-byte holdoff: counts idle cycles, saturates, and flags when the gap has elapsed.
module holdoff_timer #(
    parameter int unsigned W = 13
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    output logic o_expired_c
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (!o_expired_c) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign o_expired_c = &r_cnt;

endmodule

// File: rtl/frame_dump_ctrl.sv
// Dumps the downsampled frame buffer over the UART: sync header, then every word MSB first.
module frame_dump_ctrl
    import frame_dump_pkg::*;
#(
    parameter int unsigned WIDTH     = WIDTH_DEF,
    parameter int unsigned HEIGHT    = HEIGHT_DEF,
    parameter int unsigned HOLDOFF_W = HOLDOFF_W_DEF,
    parameter logic [7:0]  SYNC0     = SYNC0_DEF,
    parameter logic [7:0]  SYNC1     = SYNC1_DEF,
    localparam int unsigned X_W      = idx_w(WIDTH),
    localparam int unsigned Y_W      = idx_w(HEIGHT)
) (
    input  logic           sys_clk_i,
    input  logic           sys_rst_i,
    input  logic           start,
    input  logic           continuous,
    input  logic           frame_done,
    output logic [X_W-1:0] read_x,
    output logic [Y_W-1:0] read_y,
    input  logic [31:0]    read_q,
    input  logic           uart_busy,
    output logic           uart_wr,
    output logic [7:0]     uart_dat,
    output logic           busy,
    output logic           dump_done
);

    state_t         r_state;
    state_t         r_ret;
    logic           r_armed;
    logic [X_W-1:0] r_x;
    logic [Y_W-1:0] r_y;
    logic [1:0]     r_z;
    logic [31:0]    r_word;
    logic [2:0]     r_wait;
    logic           r_seen;
    logic           r_uart_wr;
    logic [7:0]     r_uart_dat;
    logic           r_busy;
    logic           r_dump_done;

    logic       w_expired;
    logic       w_go;
    logic       w_clear;
    logic       w_ready;
    logic       w_sent;
    logic       w_last;
    logic [7:0] w_byte;

    // Gap restarts at dump start and at every write so pacing holds even if the UART never reports busy.
    assign w_go    = (r_state == ST_IDLE) && frame_done && (r_armed || start || continuous);
    assign w_clear = uart_busy || r_uart_wr || w_go;
    assign w_ready = w_expired && !uart_busy && !r_uart_wr;
    assign w_sent  = (r_state == ST_WBUSY) && !uart_busy
                     && (r_seen || (r_wait == 3'(TIMEOUT_CYC - 1)));
    assign w_last  = (r_x == X_W'(WIDTH - 1)) && (r_y == Y_W'(HEIGHT - 1)) && (r_z == 2'd3);

    holdoff_timer #(
        .W (HOLDOFF_W)
    ) u_holdoff (
        .i_clk       (sys_clk_i),
        .i_rst       (sys_rst_i),
        .i_clear     (w_clear),
        .o_expired_c (w_expired)
    );

    always_comb begin
        w_byte = r_word[31:24];
        case (r_z)
            2'd1:    w_byte = r_word[23:16];
            2'd2:    w_byte = r_word[15:8];
            2'd3:    w_byte = r_word[7:0];
            default: w_byte = r_word[31:24];
        endcase
    end

    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            r_state     <= ST_IDLE;
            r_ret       <= ST_IDLE;
            r_armed     <= 1'b0;
            r_x         <= '0;
            r_y         <= '0;
            r_z         <= '0;
            r_word      <= '0;
            r_wait      <= '0;
            r_seen      <= 1'b0;
            r_uart_wr   <= 1'b0;
            r_uart_dat  <= '0;
            r_busy      <= 1'b0;
            r_dump_done <= 1'b0;
        end else begin
            r_uart_wr   <= 1'b0;
            r_dump_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_go) begin
                        r_state <= ST_HDR0;
                        r_armed <= 1'b0;
                        r_x     <= '0;
                        r_y     <= '0;
                        r_z     <= '0;
                        r_busy  <= 1'b1;
                    end else if (start || continuous) begin
                        r_armed <= 1'b1;
                    end
                end
                ST_HDR0, ST_HDR1, ST_BYTE: begin
                    if (w_ready) begin
                        r_uart_wr <= 1'b1;
                        r_wait    <= '0;
                        r_seen    <= 1'b0;
                        r_state   <= ST_WBUSY;
                        if (r_state == ST_HDR0) begin
                            r_uart_dat <= SYNC0;
                            r_ret      <= ST_HDR1;
                        end else if (r_state == ST_HDR1) begin
                            r_uart_dat <= SYNC1;
                            r_ret      <= ST_ADDR;
                        end else begin
                            r_uart_dat <= w_byte;
                            r_ret      <= ST_BYTE;
                        end
                    end
                end
                ST_ADDR: begin
                    r_state <= ST_LATCH;
                end
                ST_LATCH: begin
                    r_word  <= read_q;
                    r_state <= ST_BYTE;
                end
                ST_WBUSY: begin
                    if (uart_busy) begin
                        r_seen <= 1'b1;
                    end else if (w_sent) begin
                        if (r_ret != ST_BYTE) begin
                            r_state <= r_ret;
                        end else if (r_z != 2'd3) begin
                            r_z     <= r_z + 2'd1;
                            r_state <= ST_BYTE;
                        end else if (w_last) begin
                            r_z         <= '0;
                            r_state     <= ST_IDLE;
                            r_busy      <= 1'b0;
                            r_dump_done <= 1'b1;
                            r_armed     <= continuous;
                        end else begin
                            r_z     <= '0;
                            r_state <= ST_ADDR;
                            if (r_x == X_W'(WIDTH - 1)) begin
                                r_x <= '0;
                                r_y <= r_y + Y_W'(1);
                            end else begin
                                r_x <= r_x + X_W'(1);
                            end
                        end
                    end else begin
                        r_wait <= r_wait + 3'd1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign read_x    = r_x;
    assign read_y    = r_y;
    assign uart_wr   = r_uart_wr;
    assign uart_dat  = r_uart_dat;
    assign busy      = r_busy;
    assign dump_done = r_dump_done;

endmodule

// File: tb/tb_frame_dump_ctrl.sv
// Randomized bench for frame_dump_ctrl: buffer/UART models plus a byte-stream reference.
module tb_frame_dump_ctrl;

    localparam int unsigned WIDTH     = 2;
    localparam int unsigned HEIGHT    = 2;
    localparam int unsigned HOLDOFF_W = 4;
    localparam int unsigned X_W       = 1;
    localparam int unsigned Y_W       = 1;
    localparam int          GAP       = (1 << HOLDOFF_W) - 1;
    localparam int          NBYTES    = 2 + 4 * WIDTH * HEIGHT;

    logic           clk;
    logic           sys_rst_i;
    logic           start;
    logic           continuous;
    logic           frame_done;
    logic [X_W-1:0] read_x;
    logic [Y_W-1:0] read_y;
    logic [31:0]    read_q;
    logic           uart_busy;
    logic           uart_wr;
    logic [7:0]     uart_dat;
    logic           busy;
    logic           dump_done;

    logic           uart_en;
    logic [7:0]     salt;
    int             busy_left;
    int             n_checks;
    int             n_pass;
    int             cyc;
    int             idx;
    int             last_wr;
    int             start_cyc;
    int             wr_total;
    int             done_cnt;
    logic           prev_busy;
    logic [X_W-1:0] px;
    logic [Y_W-1:0] py;

    frame_dump_ctrl #(
        .WIDTH     (WIDTH),
        .HEIGHT    (HEIGHT),
        .HOLDOFF_W (HOLDOFF_W)
    ) dut (
        .sys_clk_i  (clk),
        .sys_rst_i  (sys_rst_i),
        .start      (start),
        .continuous (continuous),
        .frame_done (frame_done),
        .read_x     (read_x),
        .read_y     (read_y),
        .read_q     (read_q),
        .uart_busy  (uart_busy),
        .uart_wr    (uart_wr),
        .uart_dat   (uart_dat),
        .busy       (busy),
        .dump_done  (dump_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    endtask

    // Byte z of buffer word (x,y): a recognisable tag mixed with a per-run salt.
    function automatic logic [7:0] tag_byte(input int x, input int y, input int z);
        return {2'(z), 3'(y), 3'(x)} ^ salt;
    endfunction

    function automatic logic [31:0] word_of(input int x, input int y);
        return {tag_byte(x, y, 0), tag_byte(x, y, 1), tag_byte(x, y, 2), tag_byte(x, y, 3)};
    endfunction

    // Expected n-th byte of a dump: header, then rows, columns, bytes MSB first.
    function automatic logic [7:0] exp_byte(input int n);
        int k;
        int w;
        if (n == 0) return 8'hA5;
        if (n == 1) return 8'h5A;
        k = n - 2;
        w = k / 4;
        return tag_byte(w % WIDTH, w / WIDTH, k % 4);
    endfunction

    // Buffer model with one cycle of read latency.
    initial begin
        px = '0;
        py = '0;
        forever begin
            @(negedge clk);
            read_q = word_of(int'(px), int'(py));
            px = read_x;
            py = read_y;
        end
    end

    // UART model: busy for a random number of cycles per byte, or never when disabled.
    initial begin
        busy_left = 0;
        uart_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (busy_left > 0) busy_left--;
            if (uart_wr && uart_en) busy_left = int'($urandom_range(12, 3));
            uart_busy = (busy_left > 0);
        end
    end

    // Output monitor against the reference byte stream and pacing rule.
    initial begin
        cyc = 0; idx = 0; last_wr = 0; start_cyc = 0; wr_total = 0; done_cnt = 0;
        prev_busy = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (sys_rst_i) begin
                idx = 0;
                prev_busy = 1'b0;
            end else begin
                if (busy && !prev_busy) begin
                    start_cyc = cyc;
                    idx = 0;
                end
                if (uart_wr) begin
                    check_eq("byte", 32'(uart_dat), 32'(exp_byte(idx)));
                    check_eq("wr_in_dump", 32'(busy), 32'd1);
                    if (idx == 0) check_eq("first_latency", 32'((cyc - (start_cyc - 1)) >= GAP), 32'd1);
                    else          check_eq("byte_spacing", 32'((cyc - last_wr) >= GAP), 32'd1);
                    idx++;
                    wr_total++;
                    last_wr = cyc;
                end
                if (dump_done) begin
                    check_eq("frame_len", 32'(idx), 32'(NBYTES));
                    done_cnt++;
                end
                prev_busy = busy;
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic pulse_frame();
        @(negedge clk); frame_done = 1'b1;
        @(negedge clk); frame_done = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int d0;
        int n;
        d0 = done_cnt;
        n = 0;
        while (done_cnt == d0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, 32'(done_cnt > d0), 32'd1);
    endtask

    task automatic check_quiet(input string tag);
        check_eq({tag, "_wr"},   32'(uart_wr),   32'd0);
        check_eq({tag, "_dat"},  32'(uart_dat),  32'd0);
        check_eq({tag, "_busy"}, 32'(busy),      32'd0);
        check_eq({tag, "_done"}, 32'(dump_done), 32'd0);
        check_eq({tag, "_x"},    32'(read_x),    32'd0);
        check_eq({tag, "_y"},    32'(read_y),    32'd0);
    endtask

    initial begin
        int w0;
        int n;
        n_checks = 0;
        n_pass = 0;
        salt = 8'($urandom);
        uart_en = 1'b1;
        start = 1'b0;
        continuous = 1'b0;
        frame_done = 1'b0;
        sys_rst_i = 1'b1;
        idle(3);
        check_quiet("reset");
        sys_rst_i = 1'b0;

        // Single dump; a start issued mid-dump must not arm another.
        pulse_start();
        idle(5);
        check_eq("armed_waits_frame", 32'(busy), 32'd0);
        w0 = wr_total;
        pulse_frame();
        check_eq("dump_begins", 32'(busy), 32'd1);
        idle(50);
        pulse_start();
        wait_done("dump1_done", 3000);
        check_eq("dump1_bytes", 32'(wr_total - w0), 32'(NBYTES));
        idle(20);
        pulse_frame();
        idle(3);
        check_eq("start_while_busy_ignored", 32'(busy), 32'd0);

        // Armed but no frame_done: nothing is sent.
        pulse_start();
        w0 = wr_total;
        idle(1000);
        check_eq("no_frame_no_wr", 32'(wr_total - w0), 32'd0);
        check_eq("no_frame_idle", 32'(busy), 32'd0);
        pulse_frame();
        check_eq("late_frame_begins", 32'(busy), 32'd1);
        wait_done("dump2_done", 3000);

        // Continuous mode: three dumps, an extra frame_done inside the first is dropped.
        continuous = 1'b1;
        w0 = wr_total;
        for (int k = 0; k < 3; k++) begin
            idle(30);
            pulse_frame();
            check_eq("cont_begins", 32'(busy), 32'd1);
            if (k == 0) begin
                idle(150);
                pulse_frame();
            end
            wait_done("cont_done", 3000);
        end
        check_eq("cont_bytes", 32'(wr_total - w0), 32'(3 * NBYTES));
        idle(300);
        check_eq("cont_no_extra", 32'(busy), 32'd0);
        check_eq("cont_no_extra_wr", 32'(wr_total - w0), 32'(3 * NBYTES));
        continuous = 1'b0;

        // Reset in the middle of the data bytes.
        pulse_start();
        pulse_frame();
        w0 = wr_total;
        n = 0;
        while (wr_total - w0 < 6 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check_eq("mid_dump_reached", 32'(wr_total - w0 >= 6), 32'd1);
        idle(20);
        sys_rst_i = 1'b1;
        idle(2);
        check_quiet("midreset");
        sys_rst_i = 1'b0;
        w0 = wr_total;
        idle(200);
        check_eq("post_reset_no_wr", 32'(wr_total - w0), 32'd0);
        check_eq("post_reset_idle", 32'(busy), 32'd0);
        pulse_start();
        pulse_frame();
        wait_done("restart_done", 3000);
        check_eq("restart_bytes", 32'(wr_total - w0), 32'(NBYTES));

        // UART never reports busy: WBUSY timeout advances; start & frame_done together.
        uart_en = 1'b0;
        idle(30);
        w0 = wr_total;
        @(negedge clk);
        start = 1'b1;
        frame_done = 1'b1;
        @(negedge clk);
        start = 1'b0;
        frame_done = 1'b0;
        check_eq("same_cycle_start", 32'(busy), 32'd1);
        wait_done("timeout_done", 3000);
        check_eq("timeout_bytes", 32'(wr_total - w0), 32'(NBYTES));

        idle(5);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: bench did not finish, checks %0d", n_checks);
        $fatal(1);
    end

endmodule
